// File: rtl/virtual_input_encoder_pkg.sv
// Shared definitions for the virtual-input link encoder: vector geometry,
// reset mirror, resync code and FSM state encoding.
package virtual_input_encoder_pkg;

  localparam int NUM_BUTTONS  = 4;
  localparam int NUM_SWITCHES = 18;
  localparam int NUM_INPUTS   = NUM_BUTTONS + NUM_SWITCHES;

  localparam logic [NUM_INPUTS-1:0] RESET_MIRROR = 22'h3C0000;
  localparam logic [4:0]            RESYNC_CODE  = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_GAP
  } vi_state_e;

  // Index i addresses vector bit 21-i; out-of-range codes address nothing.
  function automatic logic [NUM_INPUTS-1:0] toggle_mask(input logic [4:0] code);
    toggle_mask = '0;
    if (code < 5'(NUM_INPUTS))
      toggle_mask = NUM_INPUTS'(1) << (5'(NUM_INPUTS - 1) - code);
  endfunction

endpackage

// File: rtl/virtual_input_encoder_if.sv
// Host-side bundle of the virtual-input encoder: target vector and resync
// request in, link code / strobe and status out.
interface virtual_input_encoder_if;
  import virtual_input_encoder_pkg::*;

  logic [NUM_BUTTONS-1:0]  target_buttons;
  logic [NUM_SWITCHES-1:0] target_switches;
  logic                    sync_req;
  logic [4:0]              number;
  logic                    control;
  logic                    busy;
  logic                    in_sync;

  modport master (
    output target_buttons, target_switches, sync_req,
    input  number, control, busy, in_sync
  );

  modport slave (
    input  target_buttons, target_switches, sync_req,
    output number, control, busy, in_sync
  );

endinterface

// File: rtl/virtual_input_encoder_priority_index.sv
// Picks the highest set bit of the mismatch vector and returns it as a link
// index (lowest code first), plus a valid flag.
module vi_priority_index
  import virtual_input_encoder_pkg::*;
(
  input  logic [NUM_INPUTS-1:0] mismatch_i,
  output logic [4:0]            index_o,
  output logic                  valid_o
);

  // Ascending scan: the last hit is the highest bit, i.e. the lowest index.
  always_comb begin
    index_o = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (mismatch_i[i]) begin
        index_o = 5'(NUM_INPUTS - 1 - i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/virtual_input_encoder.sv
// Virtual-input link encoder: mirrors the remote buttons/switches and sends one
// toggle (or resync) transaction at a time until the mirror matches the target.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | compare target with mirror; start resync or toggle
//  ST_SETUP | number stable, control low, SETUP_CYCLES cycles
//  ST_HIGH  | control high HIGH_CYCLES cycles; mirror updated on entry
//  ST_GAP   | control low GAP_CYCLES cycles, number still held
module virtual_input_encoder
  import virtual_input_encoder_pkg::*;
#(
  parameter int SETUP_CYCLES = 2,
  parameter int HIGH_CYCLES  = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  virtual_input_encoder_if.slave vi
);

  localparam int CNT_W = 8;

  vi_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4:0]            number_q, number_d;
  logic [NUM_INPUTS-1:0] mirror_q, mirror_d;
  logic                  pend_sync_q, pend_sync_d;
  logic                  resync_q, resync_d;
  logic                  control_q, control_d;
  logic                  in_sync_q, in_sync_d;

  logic [NUM_INPUTS-1:0] want;
  logic [4:0]            mis_index;
  logic                  mis_valid;

  assign want = {vi.target_buttons, vi.target_switches};

  vi_priority_index u_prio (
    .mismatch_i (want ^ mirror_q),
    .index_o    (mis_index),
    .valid_o    (mis_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    number_d    = number_q;
    mirror_d    = mirror_q;
    pend_sync_d = pend_sync_q | vi.sync_req;
    resync_d    = resync_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_sync_q || vi.sync_req) begin
          number_d = RESYNC_CODE;
          resync_d = 1'b1;
          state_d  = ST_SETUP;
          cnt_d    = CNT_W'(SETUP_CYCLES - 1);
        end else if (mis_valid) begin
          number_d = mis_index;
          resync_d = 1'b0;
          state_d  = ST_SETUP;
          cnt_d    = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_W'(HIGH_CYCLES - 1);
          // The remote acts on this rising edge, so the mirror follows now.
          if (resync_q) begin
            mirror_d    = RESET_MIRROR;
            pend_sync_d = vi.sync_req;
          end else begin
            mirror_d = mirror_q ^ toggle_mask(number_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    control_d = (state_d == ST_HIGH);
    in_sync_d = (state_d == ST_IDLE) && (mirror_d == want) && !pend_sync_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      number_q    <= '0;
      mirror_q    <= RESET_MIRROR;
      pend_sync_q <= 1'b1;
      resync_q    <= 1'b0;
      control_q   <= 1'b0;
      in_sync_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      number_q    <= number_d;
      mirror_q    <= mirror_d;
      pend_sync_q <= pend_sync_d;
      resync_q    <= resync_d;
      control_q   <= control_d;
      in_sync_q   <= in_sync_d;
    end
  end

  assign vi.number  = number_q;
  assign vi.control = control_q;
  assign vi.busy    = (state_q != ST_IDLE);
  assign vi.in_sync = in_sync_q;

endmodule
